// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file, the control unit and
// the ALU operand path.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Register 0 reads as zero and ignores writes
  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port of the register file.
// Forces index 0 to zero. When REGFILE_BYPASS_EN is defined, a write that
// targets the selected index in the same cycle is forwarded to the output.
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0][DATA_W-1:0] reg_view,
  input  logic [ADDR_W-1:0]               rd_addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
`endif
  output logic [DATA_W-1:0]               rd_data
);

  // Select the addressed register, zero for r0, optionally forward the write
  always_comb begin
    rd_data = '0;
    if (rd_addr != ZERO_REG) begin
      rd_data = reg_view[rd_addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr != ZERO_REG) && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/regfile32x32.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous
// write port, r0 hardwired to zero, synchronous active-low reset.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding.
module regfile32x32
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  // Only r1..r31 have storage
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] reg_view;

  // Per-register compare keeps an unknown enable or index from touching other entries
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (RegWrite && (WriteReg == reg_addr_t'(i))) begin
        regs_d[i] = WriteData;
      end
    end
  end

  // Storage update; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Flag an unknown write enable outside reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(RegWrite))
        else $error("regfile32x32: RegWrite is unknown while out of reset");
    end
  end

  // Full 32-entry view with a constant zero in slot 0
  assign reg_view = {regs_q, DATA_W'(0)};

`ifdef REGFILE_BYPASS_EN
  logic bypass_en;

  // Forwarding is disabled while reset is asserted
  assign bypass_en = RegWrite && rst_n;

  regfile_read_port u_read_port1 (
    .reg_view (reg_view),
    .rd_addr  (ReadReg1),
    .wr_en    (bypass_en),
    .wr_addr  (WriteReg),
    .wr_data  (WriteData),
    .rd_data  (ReadData1)
  );

  regfile_read_port u_read_port2 (
    .reg_view (reg_view),
    .rd_addr  (ReadReg2),
    .wr_en    (bypass_en),
    .wr_addr  (WriteReg),
    .wr_data  (WriteData),
    .rd_data  (ReadData2)
  );
`else
  regfile_read_port u_read_port1 (
    .reg_view (reg_view),
    .rd_addr  (ReadReg1),
    .rd_data  (ReadData1)
  );

  regfile_read_port u_read_port2 (
    .reg_view (reg_view),
    .rd_addr  (ReadReg2),
    .rd_data  (ReadData2)
  );
`endif

endmodule

// File: tb/tb_regfile32x32.sv
// Self-checking bench for regfile32x32: directed cases followed by random
// traffic compared against a simple array model of the register file.
module tb_regfile32x32;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  logic [31:0] model_regs [32];
  int pass_count  = 0;
  int check_count = 0;
  int fail_count  = 0;

  regfile32x32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  always #5 clk = ~clk;

  // What a read of idx should show right now, given the model and the pending write
  function automatic logic [31:0] expected_read(input logic [4:0] idx);
    logic [31:0] v;
    v = (idx == 5'd0) ? 32'h0 : model_regs[idx];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && RegWrite && (WriteReg != 5'd0) && (WriteReg == idx)) v = WriteData;
`endif
    return v;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    ReadReg1 = r1;
    ReadReg2 = r2;
    #1;
    checkValue($sformatf("%s/p1[%0d]", tag, r1), ReadData1, expected_read(r1));
    checkValue($sformatf("%s/p2[%0d]", tag, r2), ReadData2, expected_read(r2));
  endtask

  // Drive write-side inputs mid-cycle so they are stable well before the edge
  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd);
    @(negedge clk);
    rst_n     = rst;
    RegWrite  = we;
    WriteReg  = wa;
    WriteData = wd;
  endtask

  // Advance one rising edge and apply the architectural update to the model
  task automatic clockEdge();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end else if (RegWrite && (WriteReg != 5'd0)) begin
      model_regs[WriteReg] = WriteData;
    end
    #1;
  endtask

  initial begin
    logic [31:0] rdw_expected;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // Initial reset, then every index on both ports reads zero
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    clockEdge();
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) checkOutput("reset_init", 5'(i), 5'(31 - i));

    // Reset clears a written register; reset low between edges does nothing yet
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("pre_reset_r5", 5'd5, 5'd5);
    checkValue("pre_reset_r5_const", ReadData1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    checkValue("reset_between_edges", ReadData1, 32'hDEAD_BEEF);
    clockEdge();
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("post_reset_r5", 5'd5, 5'd5);
    checkValue("post_reset_r5_const", ReadData1, 32'h0);
    for (int i = 0; i < 32; i++) checkOutput("post_reset_all", 5'(i), 5'(i));

    // Basic write and read through both ports; neighbours unaffected
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h1234_5678);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("basic_r7", 5'd7, 5'd7);
    checkValue("basic_r7_const", ReadData2, 32'h1234_5678);
    checkOutput("basic_neighbours", 5'd6, 5'd8);

    // Write to r0 is discarded
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    checkOutput("zero_before", 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("zero_after", 5'd0, 5'd0);
    checkValue("zero_after_const", ReadData1, 32'h0);

    // Reset dominates a simultaneous write; no forwarding during reset
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0077);
    clockEdge();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5);
    checkOutput("rst_vs_wr_before", 5'd3, 5'd7);
    checkValue("rst_vs_wr_before_const", ReadData1, 32'h0000_0077);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("rst_vs_wr_after", 5'd3, 5'd3);
    checkValue("rst_vs_wr_after_const", ReadData1, 32'h0);

    // Read during write on the same index
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_0011);
    clockEdge();
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h0000_0022);
    checkOutput("rdw_before", 5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
    rdw_expected = 32'h0000_0022;
`else
    rdw_expected = 32'h0000_0011;
`endif
    checkValue("rdw_before_const", ReadData1, rdw_expected);
    clockEdge();
    checkValue("rdw_after_const", ReadData1, 32'h0000_0022);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("rdw_after", 5'd9, 5'd9);

    // Walking one into every register, then read everything back
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i), 32'h1 << i);
      clockEdge();
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      checkOutput("walk", 5'(i), 5'(i));
      checkValue($sformatf("walk_const[%0d]", i), ReadData1,
                 (i == 0) ? 32'h0 : (32'h1 << i));
    end

    // Random traffic with occasional reset and frequent index collisions
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      logic [4:0] ra1;
      logic [4:0] ra2;
      wa  = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), wa, $urandom);
      checkOutput("rand_pre", ra1, ra2);
      clockEdge();
      checkOutput("rand_post", ra1, ra2);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/regfile32x32.md
Name: regfile32x32

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle processor.
- Sits directly upstream of the ALU. ReadData1/ReadData2 feed the ALU operand inputs (A, B) of the bitwise, add and sub units.
- The ALU result (or load data) returns through the WriteData port.
- Two asynchronous read ports, one synchronous write port; register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the read/write data ports
- ADDR_W, 5, register-select width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- RegWrite  input  1  write enable from the control unit
- WriteReg  input  ADDR_W  destination register index
- WriteData  input  DATA_W  data to write (ALU result or memory data)
- ReadReg1  input  ADDR_W  source register index, port 1
- ReadReg2  input  ADDR_W  source register index, port 2
- ReadData1  output  DATA_W  contents of ReadReg1, to ALU operand A
- ReadData2  output  DATA_W  contents of ReadReg2, to ALU operand B

Behaviour:
- Storage: registers 1..31 are DATA_W-bit flops. Register 0 has no storage and always reads 32'h0000_0000.
- Reset: rst_n low at a rising edge clears registers 1..31 to 0 on that edge.
  - Reset is synchronous; rst_n low between edges has no effect until the next edge.
  - Reset dominates a simultaneous write: RegWrite=1 with rst_n=0 leaves the target register 0.
  - Outputs after reset: ReadData1 = ReadData2 = 0 for every index.
- Read: purely combinational, zero-cycle latency.
  - ReadDataN = 0 when ReadRegN == 0; otherwise the current register contents.
  - Both ports are independent and may select the same index.
- Write: on a rising edge with rst_n=1, RegWrite=1 and WriteReg != 0, the register at WriteReg takes WriteData.
  - The new value is visible on the read ports after that edge.
  - RegWrite=0 leaves all state unchanged.
  - WriteReg == 0 with RegWrite=1 is silently discarded; register 0 still reads 0.
- Read-during-write, same index, same cycle (bypass not compiled): read ports return the OLD value until the edge, then the new one.
- X handling: an X on RegWrite or WriteReg must not corrupt unrelated registers in simulation; the block asserts an error message if RegWrite is X while rst_n=1.
- No internal state machine beyond the storage array. The block holds no pipeline registers; the processor remains single-cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through forwarding. If RegWrite=1, WriteReg != 0 and WriteReg == ReadRegN, then ReadDataN = WriteData combinationally in the same cycle. The stored value still updates at the edge. Reset (rst_n=0) suppresses the bypass, so reads return stored/zero values.
- Not defined: no forwarding; same-cycle reads return the stored (old) value, as in Behaviour.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd0
  - typedefs reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits)
- These are also used by the control unit and the ALU operand path.
- One natural sub-module, regfile_read_port, instantiated twice:
  - inputs: the 32-entry array view, an index and, under REGFILE_BYPASS_EN, the write-side signals
  - outputs: zero-forced and optionally bypassed read data
- The write logic and storage stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 edges after writing 32'hDEAD_BEEF to r5 -> r5 reads 0; all 32 indices read 0 on both ports.
- Basic write/read: RegWrite=1, WriteReg=7, WriteData=32'h1234_5678, one edge -> ReadReg1=7 gives 32'h1234_5678; ReadReg2=7 gives same; r6 and r8 remain 0.
- Zero register: RegWrite=1, WriteReg=0, WriteData=32'hFFFF_FFFF -> ReadData1 with ReadReg1=0 stays 32'h0 before and after the edge.
- Reset vs write: rst_n=0 and RegWrite=1, WriteReg=3, WriteData=32'hA5A5_A5A5 at same edge -> r3 reads 0.
- Read-during-write: r9 holds 32'h0000_0011; write 32'h0000_0022 to r9 with ReadReg1=9.
  - Without REGFILE_BYPASS_EN: ReadData1=32'h11 before the edge, 32'h22 after.
  - With REGFILE_BYPASS_EN: ReadData1=32'h22 in the same cycle.
- Walking write: write 32'h1<<i to register i for i=1..31, then read all through both ports -> each register returns its own value, r0 returns 0, no aliasing.
